select_adder_arbiter: RTL
=========================

// Module: select_adder_arbiter
// PURPOSE
//  Shares one pipelined carry-select adder (eight_bit_select_adder class) among N_REQ requesters.
//  Round-robin arbitration with a valid/ready handshake, one issue per cycle.
//  Tags each issue with its requester index, matches results back after the adder latency,
//  and returns each result on a one-hot response strobe. Sits between client blocks and the adder.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2)
//  WIDTH  8  operand/sum width
//  LAT    2  adder latency: add_sum/add_cout in cycle k reflect add_a/add_b/add_cin of cycle k-LAT
// PORTS
//  clk        in   1            clock, all state on rising edge
//  reset_n    in   1            reset, asynchronous, active-low
//  issue_en   in   1            1 = grants allowed; 0 = no new grants, in-flight ops drain
//  req_valid  in   N_REQ        request i presents operands
//  req_ready  out  N_REQ        one-hot grant; handshake i = req_valid[i] & req_ready[i]
//  req_a      in   N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   N_REQ*WIDTH  operand B, same packing
//  req_cin    in   N_REQ        carry-in per requester
//  add_a      out  WIDTH        registered operand A to adder
//  add_b      out  WIDTH        registered operand B to adder
//  add_cin    out  1            registered carry-in to adder
//  add_sum    in   WIDTH        adder sum
//  add_cout   in   1            adder carry-out
//  rsp_valid  out  N_REQ        one-hot 1-cycle response strobe, registered
//  rsp_sum    out  WIDTH        response sum, valid when |rsp_valid
//  rsp_cout   out  1            response carry-out, valid when |rsp_valid
//  inflight   out  $clog2(LAT+2) accepted ops not yet responded (0..LAT+1)
// BEHAVIOUR
//  Reset: req_ready=0, add_a/add_b/add_cin=0, rsp_valid=0, rsp_sum/rsp_cout=0, inflight=0,
//   tag pipe cleared, RR pointer = N_REQ-1 (requester 0 has top priority first).
//  Arbitration (combinational): if issue_en, grant the first requester with req_valid set,
//   searching from ptr+1 upward, wrapping modulo N_REQ. req_ready is one-hot or zero;
//   req_ready is 0 for every requester with req_valid=0. Requesters must not gate valid on ready.
//  On handshake edge E: operand regs load granted A/B/Cin; tag stage 0 loads {1,index}; ptr <= index.
//   No handshake: operand regs load 0, tag stage 0 loads valid=0; ptr unchanged.
//  Tag pipe: LAT+1 stages, shifts every edge unconditionally. Adder result for issue at E is
//   present in the cycle after edge E+LAT; captured into rsp regs at edge E+LAT+1 when the
//   last tag stage is valid -> rsp_valid[index]=1 for exactly one cycle after that edge.
//   Latency: response visible LAT+1 edges after accept edge. Throughput: 1 op/cycle, no bubbles.
//  No last-stage valid tag: rsp_valid=0, rsp_sum/rsp_cout hold previous value.
//  Responses have no backpressure; requester must accept on the strobe.
//  Width rule: {rsp_cout,rsp_sum} = A + B + Cin, WIDTH+1 bits, no truncation.
//  inflight = count of valid tags; +1 on accept, -1 on response, unchanged if both same edge.
//  issue_en low: grants stop same cycle; already-accepted ops still complete and respond.
//  Requester holding valid while another wins: keeps operands stable until its own handshake.
//  Reset mid-operation: all in-flight ops discarded, no responses emitted after reset release.
// TESTING
//  1 LAT=2, req0 A=0x12 B=0x34 Cin=0 accept at edge 0 -> rsp_valid=0001 after edge 3, sum 0x46 cout 0.
//  2 All 4 valid held 8 cycles -> grants 0,1,2,3,0,1,2,3; responses same order, inflight peaks 3.
//  3 req2 A=0xFF B=0x01 Cin=1 -> rsp_sum=0x01 rsp_cout=1 on rsp_valid=0100.
//  4 req1 back-to-back 5 ops then issue_en=0 with valid held -> ready=0, 5 responses, inflight->0.
//  5 reset_n low with inflight=3 -> all outputs 0 at once; no rsp_valid after release.
//  6 Random 2000 ops, random valid/issue_en vs scoreboard of (index,A+B+Cin) -> zero mismatches.

Source files
------------

// File: rtl/select_adder_arbiter.sv
// select_adder_arbiter: round-robin sharing of one pipelined adder with tagged, one-hot responses
module select_adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       issue_en,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  input  logic [N_REQ-1:0]           req_cin,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic                       add_cin,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_cout,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic [$clog2(LAT+2)-1:0]   inflight
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LAT+2);
  logic [IW-1:0] ptr, gnt_idx, cand;
  logic          found;
  logic [LAT:0]  tag_v;
  logic [IW-1:0] tag_i [LAT+1];
  // Grant the first valid requester after the previous winner; a grant is the handshake
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    cand = '0;
    req_ready = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!found && issue_en && reset_n && req_valid[cand]) begin
        found = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) req_ready[gnt_idx] = 1'b1;
  end
  // Operand registers feed the adder; idle cycles present zeros
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      add_a <= '0;
      add_b <= '0;
      add_cin <= 1'b0;
      ptr <= IW'(N_REQ-1);
    end else begin
      add_a <= found ? req_a[int'(gnt_idx)*WIDTH +: WIDTH] : '0;
      add_b <= found ? req_b[int'(gnt_idx)*WIDTH +: WIDTH] : '0;
      add_cin <= found & req_cin[gnt_idx];
      ptr <= found ? gnt_idx : ptr;
    end
  end
  // Tag pipe tracks which requester owns each adder slot, one stage past the adder latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int k = 0; k <= LAT; k++) tag_i[k] <= '0;
    end else begin
      tag_v <= {tag_v[LAT-1:0], found};
      tag_i[0] <= gnt_idx;
      for (int k = 1; k <= LAT; k++) tag_i[k] <= tag_i[k-1];
    end
  end
  // Capture the adder result for the tag leaving the pipe and strobe its owner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
    end else begin
      rsp_valid <= tag_v[LAT] ? N_REQ'(1) << tag_i[LAT] : '0;
      if (tag_v[LAT]) {rsp_cout, rsp_sum} <= {add_cout, add_sum};
    end
  end
  // Outstanding-op count: up on accept, down on response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inflight <= '0;
    else inflight <= inflight + CW'(found) - CW'(tag_v[LAT]);
  end
endmodule
